// File: rtl/trace_pattern_gen_pkg.sv
// Shared types and grid helpers for the wand-tracing target generator.
package trace_pattern_gen_pkg;

    localparam int         GRID_DIM  = 4;
    localparam int         CELLS     = 16;
    localparam logic [1:0] GRID_LAST = 2'(GRID_DIM - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_SHOW,
        ST_TRACE,
        ST_SCORE
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    function automatic logic [1:0] cell_row(input logic [3:0] idx);
        return idx[3:2];
    endfunction

    function automatic logic [1:0] cell_col(input logic [3:0] idx);
        return idx[1:0];
    endfunction

    // Returns {in_grid, neighbour_index} for one step from idx in direction dir.
    function automatic logic [4:0] cell_step(input logic [3:0] idx, input dir_e dir);
        logic [1:0] row;
        logic [1:0] col;
        logic       ok;
        row = cell_row(idx);
        col = cell_col(idx);
        ok  = 1'b0;
        case (dir)
            DIR_UP:    begin ok = (row != 2'd0);      row = row - 2'd1; end
            DIR_RIGHT: begin ok = (col != GRID_LAST); col = col + 2'd1; end
            DIR_DOWN:  begin ok = (row != GRID_LAST); row = row + 2'd1; end
            default:   begin ok = (col != 2'd0);      col = col - 2'd1; end
        endcase
        return {ok, row, col};
    endfunction

endpackage

// File: rtl/trace_pattern_gen_lfsr16.sv
// 16-bit Galois LFSR (mask 16'hB400), stepping every cycle out of reset.
module lfsr16 #(
    parameter logic [15:0] seed = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = {1'b0, q_q[15:1]};
        if (q_q[0]) begin
            q_d = q_d ^ 16'hB400;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/trace_pattern_gen.sv
// Round controller: random connected target path, timed show and trace windows, scoring.
// Optional moving snitch during TRACE is built when TRACE_SNITCH_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; last result and path held
// GEN   | growing the random path one cell per cycle
// SHOW  | target displayed for SHOW_CYCLES
// TRACE | player traces; exits on completion or timeout
// SCORE | one-cycle result strobe
module trace_pattern_gen
    import trace_pattern_gen_pkg::*;
#(
    parameter int          PATH_LEN      = 6,
    parameter int          SHOW_CYCLES   = 50_000_000,
    parameter int          TRACE_CYCLES  = 250_000_000,
    parameter int          SNITCH_CYCLES = 25_000_000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] already_traced,
    output logic [15:0] displayed_trace,
    output logic        show_trace,
    output logic        reset_trace,
    output logic [15:0] snitch_location,
    output logic        snitch_caught,
    output logic        round_done,
    output logic        round_pass,
    output logic [4:0]  hits,
    output logic [4:0]  misses
);

    localparam int TMR_MAX = (SHOW_CYCLES > TRACE_CYCLES) ? SHOW_CYCLES : TRACE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < CELLS; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    logic [15:0] lfsr;
    logic        unused_lfsr_hi;

    lfsr16 #(.seed(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:4];

    state_e             state_q,  state_d;
    logic [15:0]        disp_q,   disp_d;
    logic [3:0]         cur_q,    cur_d;
    logic [4:0]         cnt_q,    cnt_d;
    logic [TMR_W-1:0]   tmr_q,    tmr_d;
    logic [1:0]         guard_q,  guard_d;
    logic [4:0]         hits_q,   hits_d;
    logic [4:0]         misses_q, misses_d;
    logic               pass_q,   pass_d;

    logic [4:0]  step_cell;
    logic        found;
    logic [3:0]  next_cell;
    logic [4:0]  score_hits;
    logic [4:0]  score_misses;
    logic        complete;

    // First in-grid, unvisited neighbour scanning clockwise from lfsr[1:0].
    always_comb begin
        step_cell = '0;
        found     = 1'b0;
        next_cell = cur_q;
        for (int k = 0; k < 4; k++) begin
            step_cell = cell_step(cur_q, dir_e'(lfsr[1:0] + 2'(k)));
            if (!found && step_cell[4] && !disp_q[step_cell[3:0]]) begin
                found     = 1'b1;
                next_cell = step_cell[3:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        disp_d       = disp_q;
        cur_d        = cur_q;
        cnt_d        = cnt_q;
        tmr_d        = tmr_q;
        guard_d      = guard_q;
        hits_d       = hits_q;
        misses_d     = misses_q;
        pass_d       = pass_q;
        score_hits   = popcount16(already_traced & disp_q);
        score_misses = popcount16(already_traced & ~disp_q);
        complete     = ((already_traced & disp_q) == disp_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_GEN;
                    disp_d   = 16'd1 << lfsr[3:0];
                    cur_d    = lfsr[3:0];
                    cnt_d    = 5'd1;
                    hits_d   = '0;
                    misses_d = '0;
                    pass_d   = 1'b0;
                end
            end
            ST_GEN: begin
                if (!found) begin
                    disp_d = 16'd1 << lfsr[3:0];
                    cur_d  = lfsr[3:0];
                    cnt_d  = 5'd1;
                end else begin
                    disp_d = disp_q | (16'd1 << next_cell);
                    cur_d  = next_cell;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'(PATH_LEN - 1)) begin
                        state_d = ST_SHOW;
                        tmr_d   = TMR_W'(SHOW_CYCLES - 1);
                    end
                end
            end
            ST_SHOW: begin
                if (tmr_q == '0) begin
                    state_d = ST_TRACE;
                    tmr_d   = TMR_W'(TRACE_CYCLES - 1);
                    guard_d = 2'd2;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_TRACE: begin
                if (guard_q != 2'd0) begin
                    guard_d = guard_q - 2'd1;
                end
                // guard_q masks the stale grid contents during the first two cycles
                if ((guard_q == 2'd0 && complete) || tmr_q == '0) begin
                    state_d  = ST_SCORE;
                    hits_d   = score_hits;
                    misses_d = score_misses;
                    pass_d   = (score_hits == 5'(PATH_LEN)) && (score_misses == 5'd0);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_SCORE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            disp_q   <= '0;
            cur_q    <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            guard_q  <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            disp_q   <= disp_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            guard_q  <= guard_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            pass_q   <= pass_d;
        end
    end

`ifdef TRACE_SNITCH_EN
    localparam int SNT_W = $clog2(SNITCH_CYCLES + 1);

    logic [15:0]      snitch_q,  snitch_d;
    logic             caught_q,  caught_d;
    logic [SNT_W-1:0] snt_tmr_q, snt_tmr_d;
    logic [15:0]      snitch_cand;

    always_comb begin
        snitch_d    = snitch_q;
        caught_d    = caught_q;
        snt_tmr_d   = snt_tmr_q;
        snitch_cand = 16'd1 << lfsr[3:0];
        if (state_q == ST_IDLE && start) begin
            caught_d = 1'b0;
        end
        if (state_q == ST_SHOW && state_d == ST_TRACE) begin
            snitch_d  = ((snitch_cand & disp_q) != '0) ? '0 : snitch_cand;
            snt_tmr_d = SNT_W'(SNITCH_CYCLES - 1);
        end else if (state_q == ST_TRACE) begin
            if ((already_traced & snitch_q) != '0) begin
                caught_d = 1'b1;
            end
            if (state_d != ST_TRACE) begin
                snitch_d = '0;
            end else if (snt_tmr_q == '0) begin
                snt_tmr_d = SNT_W'(SNITCH_CYCLES - 1);
                if ((snitch_cand & disp_q) == '0) begin
                    snitch_d = snitch_cand;
                end
            end else begin
                snt_tmr_d = snt_tmr_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snitch_q  <= '0;
            caught_q  <= 1'b0;
            snt_tmr_q <= '0;
        end else begin
            snitch_q  <= snitch_d;
            caught_q  <= caught_d;
            snt_tmr_q <= snt_tmr_d;
        end
    end

    assign snitch_location = snitch_q;
    assign snitch_caught   = caught_q;
`else
    localparam int unused_snitch_cycles = SNITCH_CYCLES;

    assign snitch_location = '0;
    assign snitch_caught   = 1'b0;
`endif

    assign displayed_trace = disp_q;
    assign show_trace      = (state_q == ST_SHOW);
    assign reset_trace     = (state_q == ST_TRACE) && (guard_q == 2'd2);
    assign round_done      = (state_q == ST_SCORE);
    assign round_pass      = pass_q;
    assign hits            = hits_q;
    assign misses          = misses_q;

endmodule

// File: tb/tb_trace_pattern_gen.sv
// Randomized self-checking bench for trace_pattern_gen against a path/round reference model.
`timescale 1ns/1ps
module tb_trace_pattern_gen;

    localparam int          PATH_LEN      = 6;
    localparam int          SHOW_CYCLES   = 4;
    localparam int          TRACE_CYCLES  = 20;
    localparam int          SNITCH_CYCLES = 3;
    localparam logic [15:0] SEED          = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] already_traced = '0;
    logic [15:0] displayed_trace;
    logic        show_trace;
    logic        reset_trace;
    logic [15:0] snitch_location;
    logic        snitch_caught;
    logic        round_done;
    logic        round_pass;
    logic [4:0]  hits;
    logic [4:0]  misses;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    trace_pattern_gen #(
        .PATH_LEN      (PATH_LEN),
        .SHOW_CYCLES   (SHOW_CYCLES),
        .TRACE_CYCLES  (TRACE_CYCLES),
        .SNITCH_CYCLES (SNITCH_CYCLES),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .already_traced  (already_traced),
        .displayed_trace (displayed_trace),
        .show_trace      (show_trace),
        .reset_trace     (reset_trace),
        .snitch_location (snitch_location),
        .snitch_caught   (snitch_caught),
        .round_done      (round_done),
        .round_pass      (round_pass),
        .hits            (hits),
        .misses          (misses)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR value for the current cycle, read at negedges.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= lfsr_next(m_lfsr);
    end

    // Random-walk path builder working on row/col coordinates.
    task automatic model_path(input logic [15:0] l0, output logic [15:0] bm, output int gen_cycles);
        logic [15:0] l;
        int cur, cnt, r, c, nr, nc, d;
        bit found;
        l = l0;
        cur = int'(l[3:0]);
        bm = '0;
        bm[cur] = 1'b1;
        cnt = 1;
        gen_cycles = 0;
        while (cnt < PATH_LEN && gen_cycles < 4000) begin
            l = lfsr_next(l);
            gen_cycles++;
            found = 0;
            for (int k = 0; k < 4 && !found; k++) begin
                d = (int'(l[1:0]) + k) % 4;
                r = cur / 4;
                c = cur % 4;
                nr = r;
                nc = c;
                case (d)
                    0: nr = r - 1;
                    1: nc = c + 1;
                    2: nr = r + 1;
                    default: nc = c - 1;
                endcase
                if (nr >= 0 && nr < 4 && nc >= 0 && nc < 4) begin
                    if (!bm[nr*4+nc]) begin
                        cur = nr * 4 + nc;
                        bm[cur] = 1'b1;
                        cnt++;
                        found = 1;
                    end
                end
            end
            if (!found) begin
                cur = int'(l[3:0]);
                bm = '0;
                bm[cur] = 1'b1;
                cnt = 1;
            end
        end
    endtask

    function automatic bit all_cells_adjacent(input logic [15:0] bm);
        int r, c;
        bit ok;
        for (int i = 0; i < 16; i++) begin
            if (bm[i]) begin
                r = i / 4;
                c = i % 4;
                ok = 0;
                if (r > 0) ok = ok | bm[i-4];
                if (r < 3) ok = ok | bm[i+4];
                if (c > 0) ok = ok | bm[i-1];
                if (c < 3) ok = ok | bm[i+1];
                if (!ok) return 0;
            end
        end
        return 1;
    endfunction

    // mode: 0 exact path, 1 path plus one stray cell, 2 nothing traced,
    //       3 random per cycle, 4 chase the snitch
    task automatic run_round(input int mode, input int start_delay, input bit abort,
                             output logic [15:0] path_out);
        logic [15:0] l0, exp_disp, l_prev, at, cand, exp_snitch;
        int gen_exp, gen_obs, sh, extra_idx;
        int exp_hits, exp_miss;
        bit exp_pass, exp_caught, done, exit_now;

        repeat (start_delay) @(negedge clk);
        l0 = m_lfsr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_path(l0, exp_disp, gen_exp);
        path_out = exp_disp;
        check_eq("start_clear", 64'({round_pass, hits, misses, snitch_caught, round_done}), 64'(0));

        gen_obs = 0;
        while (!show_trace && gen_obs < 5000) begin
            gen_obs++;
            @(negedge clk);
        end
        check_eq("gen_cycles", 64'(gen_obs), 64'(gen_exp));
        check_eq("path_bitmap", 64'(displayed_trace), 64'(exp_disp));
        check_eq("path_popcount", 64'($countones(displayed_trace)), 64'(PATH_LEN));
        check_eq("path_adjacent", 64'(all_cells_adjacent(displayed_trace)), 64'(1));

        sh = 0;
        l_prev = m_lfsr;
        while (show_trace && sh < 100) begin
            if (abort && sh == 2) begin
                #2 reset = 1'b1;
                #1;
                check_eq("abort_outputs",
                         64'({displayed_trace, show_trace, reset_trace, snitch_location,
                              snitch_caught, round_done, round_pass, hits, misses}), 64'(0));
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check_eq("abort_no_done", 64'({round_done, show_trace}), 64'(0));
                end
                reset = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check_eq("abort_idle", 64'({round_done, show_trace, reset_trace}), 64'(0));
                end
                return;
            end
            l_prev = m_lfsr;
            sh++;
            @(negedge clk);
        end
        check_eq("show_cycles", 64'(sh), 64'(SHOW_CYCLES));

        do extra_idx = int'($urandom_range(0, 15)); while (exp_disp[extra_idx]);
        exp_snitch = '0;
        exp_caught = 0;
        exp_hits = 0;
        exp_miss = 0;
        exp_pass = 0;
        done = 0;
        for (int n = 1; n <= TRACE_CYCLES && !done; n++) begin
`ifdef TRACE_SNITCH_EN
            if ((n - 1) % SNITCH_CYCLES == 0) begin
                cand = 16'd1 << l_prev[3:0];
                if ((cand & exp_disp) == '0) exp_snitch = cand;
            end
`else
            cand = '0;
`endif
            case (mode)
                0: at = exp_disp;
                1: at = exp_disp | (16'd1 << extra_idx);
                2: at = '0;
                3: begin
                    case ($urandom_range(0, 3))
                        0: at = exp_disp;
                        1: at = 16'($urandom);
                        2: at = exp_disp | (16'd1 << $urandom_range(0, 15));
                        default: at = exp_disp & 16'($urandom);
                    endcase
                end
                default: at = exp_snitch;
            endcase
            already_traced = at;
            start = (mode == 2 && n == 5);

            check_eq("trace_show", 64'(show_trace), 64'(0));
            check_eq("trace_reset_pulse", 64'(reset_trace), 64'(n == 1));
            check_eq("trace_no_done", 64'(round_done), 64'(0));
            check_eq("snitch_loc", 64'(snitch_location), 64'(exp_snitch));
            check_eq("snitch_off_path", 64'(snitch_location & displayed_trace), 64'(0));
            check_eq("snitch_caught", 64'(snitch_caught), 64'(exp_caught));

            if ((at & exp_snitch) != '0) exp_caught = 1;
            exit_now = (n >= 3 && (at & exp_disp) == exp_disp) || (n == TRACE_CYCLES);
            if (exit_now) begin
                exp_hits = $countones(at & exp_disp);
                exp_miss = $countones(at & ~exp_disp);
                exp_pass = (exp_hits == PATH_LEN) && (exp_miss == 0);
                done = 1;
            end
            l_prev = m_lfsr;
            @(negedge clk);
        end
        start = 1'b0;

        check_eq("score_done", 64'(round_done), 64'(1));
        check_eq("score_hits", 64'(hits), 64'(exp_hits));
        check_eq("score_misses", 64'(misses), 64'(exp_miss));
        check_eq("score_pass", 64'(round_pass), 64'(exp_pass));
        check_eq("score_snitch_clear", 64'(snitch_location), 64'(0));
        check_eq("score_caught", 64'(snitch_caught), 64'(exp_caught));
        already_traced = '0;
        @(negedge clk);
        check_eq("idle_done_pulse", 64'(round_done), 64'(0));
        check_eq("idle_hold", 64'({round_pass, hits, misses, snitch_caught}),
                 64'({exp_pass, 5'(exp_hits), 5'(exp_miss), exp_caught}));
        check_eq("idle_path_hold", 64'(displayed_trace), 64'(exp_disp));
    endtask

    logic [15:0] path_first;
    logic [15:0] path_tmp;
    logic [15:0] path_repro;

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 64'({displayed_trace, show_trace, reset_trace, snitch_location,
                      snitch_caught, round_done, round_pass, hits, misses}), 64'(0));
        reset = 1'b0;

        run_round(0, 3, 0, path_first);
        run_round(1, 2, 0, path_tmp);
        run_round(2, 1, 0, path_tmp);
        for (int i = 0; i < 6; i++) begin
            run_round(3, int'($urandom_range(0, 4)), 0, path_tmp);
        end
        run_round(4, 1, 0, path_tmp);
        run_round(4, 0, 0, path_tmp);

        // Abort mid-SHOW, then replay the first round's exact post-reset timing.
        run_round(0, 2, 1, path_tmp);
        run_round(0, 0, 0, path_repro);
        check_eq("repro_path", 64'(path_repro), 64'(path_first));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trace_pattern_gen.md
# trace_pattern_gen

Round controller that produces the target trace the player must copy on the 4x4 wand-tracing grid. It builds a random connected path of grid cells, shows it for a fixed time, then clears the player's trace and runs a timed trace window. At the end it scores the player's accumulated `already_traced` bitmap against the target. It sits upstream of the grid renderer, driving that block's `displayed_trace`, `reset_trace` and `snitch_location` inputs and consuming its `already_traced` output.

## Interface
- `PATH_LEN`, 6: number of cells in the target path; legal range 2..16.
- `SHOW_CYCLES`, 50_000_000: cycles the target is shown.
- `TRACE_CYCLES`, 250_000_000: player time limit in cycles.
- `SNITCH_CYCLES`, 25_000_000: snitch move period in cycles.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: starts a round; sampled only in IDLE.
- `already_traced` in 16: the player's accumulated trace; bit n is cell n; cell = row*4+col.
- `displayed_trace` out 16: target path bitmap.
- `show_trace` out 1: high while the target is displayed.
- `reset_trace` out 1: one-cycle pulse that clears the player's trace.
- `snitch_location` out 16: one-hot snitch cell, or 0.
- `snitch_caught` out 1: sticky within a round.
- `round_done` out 1: one-cycle pulse.
- `round_pass` out 1: held until the next `start`.
- `hits` out 5: popcount of target cells traced.
- `misses` out 5: popcount of non-target cells traced.

## Operation
- FSM states: IDLE, GEN, SHOW, TRACE, SCORE.
- IDLE:
  - `start`=1 → GEN.
  - `round_pass`, `hits`, `misses` and `snitch_caught` clear on this transition.
  - `displayed_trace` clears on this transition.
- GEN entry:
  - The path is the single cell `lfsr[3:0]`; the current cell is set to that cell.
  - Path count = 1.
- GEN, each cycle:
  - Direction d = `lfsr[1:0]` (0 up, 1 right, 2 down, 3 left).
  - Try d, d+1, d+2, d+3 mod 4, in that order. The first neighbour that is in-grid and not already in the path is appended and becomes the current cell.
  - If no neighbour qualifies (dead end), restart GEN entry with a fresh `lfsr[3:0]`.
  - Path count = `PATH_LEN` → SHOW.
- SHOW:
  - `show_trace`=1 for exactly `SHOW_CYCLES` cycles, then → TRACE.
- TRACE:
  - `reset_trace`=1 on the first TRACE cycle only. `show_trace`=0 throughout.
  - Completion check: `(already_traced & displayed_trace) == displayed_trace`.
  - The completion check is masked for the first 2 TRACE cycles, because stale grid state may still be present.
  - Leave to SCORE on completion, or when the timer reaches `TRACE_CYCLES`. If both happen in the same cycle, they produce the same outcome.
- SCORE, one cycle:
  - `hits` = popcount(`already_traced & displayed_trace`).
  - `misses` = popcount(`already_traced & ~displayed_trace`).
  - `round_pass` = (`hits`==`PATH_LEN`) & (`misses`==0).
  - `round_done`=1, then → IDLE.
- LFSR: 16-bit Galois, mask 16'hB400. It steps every cycle in every state.
- `start` outside IDLE is ignored.
- `displayed_trace` holds its value through SCORE and IDLE until the next GEN.

## Timing
- Reset is asynchronous. While `reset` is high:
  - State = IDLE; `lfsr` = `LFSR_SEED`.
  - Every output = 0; all timers = 0.
- Reset in any state aborts the round immediately; no `round_done` is produced.
- `start` → GEN entry: 1 cycle.
- GEN lasts at least `PATH_LEN`-1 cycles; each dead-end restart adds cycles.
- SHOW lasts exactly `SHOW_CYCLES` cycles.
- `reset_trace` rises in the cycle after `show_trace` falls.
- TRACE timeout: SCORE is entered in the cycle after the `TRACE_CYCLES`th TRACE cycle.
- `round_done` is registered: it is high in the SCORE cycle, and `hits`/`misses`/`round_pass` are valid from that same cycle.

## Configuration
- Macro: `TRACE_SNITCH_EN`.
- Defined, during TRACE:
  - `snitch_location` is one-hot.
  - Placement: every `SNITCH_CYCLES` cycles (first placement on the first TRACE cycle) it moves to cell `lfsr[3:0]`. If that cell is in `displayed_trace`, the snitch keeps its previous cell; on first placement it stays 0.
  - `already_traced & snitch_location` ≠ 0 sets `snitch_caught`.
  - `snitch_location` = 0 outside TRACE.
- Undefined: `snitch_location` and `snitch_caught` are tied to 0. The ports remain present.

## Structure
- Shared package holds:
  - The state enum.
  - Grid constants: GRID_DIM=4, CELLS=16.
  - The direction encoding.
  - The cell-index helpers (row = idx[3:2], col = idx[1:0]).
- Sub-module `lfsr16`:
  - Ports: `clk`, `reset`, `seed` parameter, `q[15:0]`.
- Popcount is a local function, not a module.

## Test plan
Bench parameters: `SHOW_CYCLES`=4, `TRACE_CYCLES`=20, `SNITCH_CYCLES`=3, `PATH_LEN`=6.
- Reset release, then `start` pulse → GEN, then `displayed_trace` popcount = 6, every path cell 4-adjacent to at least one other path cell, then `show_trace` high for exactly 4 cycles.
- After SHOW, drive `already_traced` = `displayed_trace` from the 1st TRACE cycle → no exit on cycles 1–2. Exit on cycle 3, then `round_done`, `hits`=6, `misses`=0, `round_pass`=1.
- Drive `already_traced` = `displayed_trace` | one extra cell → `hits`=6, `misses`=1, `round_pass`=0.
- Hold `already_traced`=0 → timeout after 20 TRACE cycles, then `round_done`, `hits`=0, `round_pass`=0.
- Assert `reset` mid-SHOW → all outputs 0 the same cycle, state IDLE, no `round_done`. The next `start` reproduces the first-round path sequence for an identical cycle-accurate stimulus.
- With `TRACE_SNITCH_EN`, force `already_traced` to match `snitch_location` → `snitch_caught`=1 until the next `start`. `snitch_location` is never in `displayed_trace`.
